// File: rtl/main_control_fsm.sv
// Multicycle MIPS main control: Moore FSM sequencing fetch/decode/execute/mem/writeback.
// Optional macro MAIN_CTL_ADDI_EN adds the ADDI_EXEC/ADDI_WB path for opcode OP_ADDI.
module main_control_fsm #(
  parameter logic [5:0] OP_RTYPE = 6'd0,
  parameter logic [5:0] OP_LW    = 6'd35,
  parameter logic [5:0] OP_SW    = 6'd43,
  parameter logic [5:0] OP_BEQ   = 6'd4,
  parameter logic [5:0] OP_J     = 6'd2,
  parameter logic [5:0] OP_ADDI  = 6'd8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsource,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADDR   = 4'd2,
    S_MEMREAD   = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWRITE  = 4'd5,
    S_EXEC      = 4'd6,
    S_RCOMP     = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_e;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
  } ctl_t;

  // Control word for a given state; registered alongside the state so ctl_q always matches state_q.
  function automatic ctl_t decode_ctl(input state_e s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH:     begin c.memread = 1'b1; c.irwrite = 1'b1; c.pcwrite = 1'b1; c.alusrcb = 2'b01; end
      S_DECODE:    c.alusrcb = 2'b11;
      S_MEMADDR:   begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_MEMREAD:   begin c.memread = 1'b1; c.iord = 1'b1; end
      S_MEMWB:     begin c.regwrite = 1'b1; c.memtoreg = 1'b1; end
      S_MEMWRITE:  begin c.memwrite = 1'b1; c.iord = 1'b1; end
      S_EXEC:      begin c.alusrca = 1'b1; c.aluop = 2'b10; end
      S_RCOMP:     begin c.regwrite = 1'b1; c.regdst = 1'b1; end
      S_BRANCH:    begin c.alusrca = 1'b1; c.aluop = 2'b01; c.pcwritecond = 1'b1; c.pcsource = 2'b01; end
      S_JUMP:      begin c.pcwrite = 1'b1; c.pcsource = 2'b10; end
`ifdef MAIN_CTL_ADDI_EN
      S_ADDI_EXEC: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_ADDI_WB:   c.regwrite = 1'b1;
`endif
      default:     c = '0;
    endcase
    return c;
  endfunction

  state_e     state_q, state_d;
  logic [5:0] opc_q, opc_d;
  ctl_t       ctl_q, ctl_d;
  logic       illegal_c;

  always_comb begin
    state_d   = S_FETCH;
    opc_d     = opc_q;
    illegal_c = 1'b0;
    case (state_q)
      S_FETCH:   state_d = S_DECODE;
      S_DECODE: begin
        opc_d = opcode;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADDR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef MAIN_CTL_ADDI_EN
          OP_ADDI:      state_d = S_ADDI_EXEC;
`else
          OP_ADDI:      illegal_c = 1'b1;
`endif
          default:      illegal_c = 1'b1;
        endcase
      end
      S_MEMADDR: state_d = (opc_q == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: state_d = S_MEMWB;
      S_EXEC:    state_d = S_RCOMP;
`ifdef MAIN_CTL_ADDI_EN
      S_ADDI_EXEC: state_d = S_ADDI_WB;
`endif
      default:   state_d = S_FETCH;
    endcase
    ctl_d = decode_ctl(state_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      opc_q   <= '0;
      ctl_q   <= decode_ctl(S_FETCH);
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      ctl_q   <= ctl_d;
    end
  end

  // Reset holds every output low even though the state register already reads FETCH.
  assign pcwrite     = ctl_q.pcwrite     & ~reset;
  assign pcwritecond = ctl_q.pcwritecond & ~reset;
  assign iord        = ctl_q.iord        & ~reset;
  assign memread     = ctl_q.memread     & ~reset;
  assign memwrite    = ctl_q.memwrite    & ~reset;
  assign irwrite     = ctl_q.irwrite     & ~reset;
  assign memtoreg    = ctl_q.memtoreg    & ~reset;
  assign regdst      = ctl_q.regdst      & ~reset;
  assign regwrite    = ctl_q.regwrite    & ~reset;
  assign alusrca     = ctl_q.alusrca     & ~reset;
  assign alusrcb     = ctl_q.alusrcb     & {2{~reset}};
  assign aluop       = ctl_q.aluop       & {2{~reset}};
  assign pcsource    = ctl_q.pcsource    & {2{~reset}};
  assign illegal_op  = illegal_c         & ~reset;
  assign state       = state_q           & {4{~reset}};

endmodule

// File: tb/tb_main_control_fsm.sv
// Randomized bench for main_control_fsm: per-opcode state sequences and per-state control table.
module tb_main_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic       memtoreg, regdst, regwrite, alusrca, illegal_op;
  logic [1:0] alusrcb, aluop, pcsource;
  logic [3:0] state;

  int n_tests = 0;
  int n_fail  = 0;
  int seq_q[$];

  main_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
    .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
    .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
    .pcsource(pcsource), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] obs_vec();
    return {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
            regdst, regwrite, alusrca, alusrcb, aluop, pcsource};
  endfunction

  // Control table, one row per state number, in the obs_vec bit order.
  function automatic logic [15:0] exp_vec(input int s);
    logic pw, pwc, io, mr, mw, ir, m2r, rd, rw, sa;
    logic [1:0] sb, op, ps;
    {pw, pwc, io, mr, mw, ir, m2r, rd, rw, sa} = '0;
    sb = 2'b00; op = 2'b00; ps = 2'b00;
    case (s)
      0: begin mr = 1; ir = 1; pw = 1; sb = 2'b01; end
      1: sb = 2'b11;
      2: begin sa = 1; sb = 2'b10; end
      3: begin mr = 1; io = 1; end
      4: begin rw = 1; m2r = 1; end
      5: begin mw = 1; io = 1; end
      6: begin sa = 1; op = 2'b10; end
      7: begin rw = 1; rd = 1; end
      8: begin sa = 1; op = 2'b01; pwc = 1; ps = 2'b01; end
      9: begin pw = 1; ps = 2'b10; end
`ifdef MAIN_CTL_ADDI_EN
      10: begin sa = 1; sb = 2'b10; end
      11: rw = 1;
`endif
      default: ;
    endcase
    return {pw, pwc, io, mr, mw, ir, m2r, rd, rw, sa, sb, op, ps};
  endfunction

  task automatic build_seq(input logic [5:0] op);
    seq_q = {0, 1};
    case (op)
      6'd35: seq_q = {0, 1, 2, 3, 4};
      6'd43: seq_q = {0, 1, 2, 5};
      6'd0:  seq_q = {0, 1, 6, 7};
      6'd4:  seq_q = {0, 1, 8};
      6'd2:  seq_q = {0, 1, 9};
`ifdef MAIN_CTL_ADDI_EN
      6'd8:  seq_q = {0, 1, 10, 11};
`endif
      default: ;
    endcase
  endtask

  function automatic bit is_legal(input logic [5:0] op);
`ifdef MAIN_CTL_ADDI_EN
    if (op == 6'd8) return 1'b1;
`endif
    return op inside {6'd0, 6'd35, 6'd43, 6'd4, 6'd2};
  endfunction

  // Entered and left at a negedge; outputs sampled 1ns after inputs settle.
  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      opcode = 6'($urandom);
      #1;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_outs", 32'(obs_vec()), 32'd0);
      chk("rst_illegal", 32'(illegal_op), 32'd0);
      @(negedge clk);
    end
    reset = 1'b0;
  endtask

  task automatic run_instr(input logic [5:0] op, input int abort_at);
    build_seq(op);
    for (int i = 0; i < seq_q.size(); i++) begin
      if (i == abort_at) begin
        do_reset(int'($urandom_range(1, 2)));
        return;
      end
      // Only DECODE samples the opcode; scramble it elsewhere to exercise the latch.
      opcode = (i == 1) ? op : 6'($urandom);
      #1;
      chk($sformatf("state op%0d c%0d", op, i), 32'(state), 32'(seq_q[i]));
      chk($sformatf("outs op%0d s%0d", op, seq_q[i]), 32'(obs_vec()), 32'(exp_vec(seq_q[i])));
      chk($sformatf("illegal op%0d c%0d", op, i), 32'(illegal_op),
          32'((i == 1) && !is_legal(op)));
      chk("mem_excl", 32'(memread & memwrite), 32'd0);
      chk("pc_excl", 32'(pcwrite & pcwritecond), 32'd0);
      @(negedge clk);
    end
  endtask

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 7))
      0: return 6'd0;
      1: return 6'd35;
      2: return 6'd43;
      3: return 6'd4;
      4: return 6'd2;
      5: return 6'd8;
      default: return 6'($urandom);
    endcase
  endfunction

  initial begin
    reset  = 1'b1;
    opcode = 6'd0;
    @(negedge clk);
    do_reset(3);
    run_instr(6'd35, -1);
    run_instr(6'd43, -1);
    run_instr(6'd0,  -1);
    run_instr(6'd4,  -1);
    run_instr(6'd2,  -1);
    run_instr(6'd8,  -1);
    run_instr(6'd63, -1);
    run_instr(6'd35, 3);
    run_instr(6'd35, -1);
    for (int k = 0; k < 300; k++) begin
      logic [5:0] op;
      int ab;
      op = pick_op();
      build_seq(op);
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, seq_q.size() - 1)) : -1;
      run_instr(op, ab);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
